// File: rtl/branch_predictor_bht.sv
// Branch target buffer with per-entry saturating direction counters, mispredict detection and stats.
// Optional macro BP_BYPASS_EN forwards a same-cycle update to a lookup of the same index.
module branch_predictor_bht #(
    parameter int XLEN     = 64,
    parameter int ENTRIES  = 16,
    parameter int TAG_BITS = 8,
    parameter int CTR_BITS = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
);
    localparam int IDX = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    logic [IDX-1:0]      f_idx, u_idx;
    logic [TAG_BITS-1:0] f_tag, u_tag;
    logic                u_hit;

    assign f_idx = fetch_pc[IDX+1:2];
    assign f_tag = fetch_pc[IDX+2 +: TAG_BITS];
    assign u_idx = upd_pc[IDX+1:2];
    assign u_tag = upd_pc[IDX+2 +: TAG_BITS];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // Post-update contents of the entry at u_idx; shared by the write port and the bypass.
    logic                upd_write;
    logic                nxt_valid;
    logic [TAG_BITS-1:0] nxt_tag;
    logic [XLEN-1:0]     nxt_target;
    logic [CTR_BITS-1:0] nxt_ctr;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        upd_write  = 1'b0;
        nxt_valid  = valid_q[u_idx];
        nxt_tag    = tag_q[u_idx];
        nxt_target = target_q[u_idx];
        nxt_ctr    = ctr_q[u_idx];
        if (upd_valid) begin
            if (u_hit) begin
                upd_write = 1'b1;
                if (upd_taken) begin
                    nxt_target = upd_target;
                    if (ctr_q[u_idx] != CTR_MAX) nxt_ctr = ctr_q[u_idx] + CTR_BITS'(1);
                end else if (ctr_q[u_idx] != '0) begin
                    nxt_ctr = ctr_q[u_idx] - CTR_BITS'(1);
                end
            end else if (upd_taken) begin
                upd_write  = 1'b1;
                nxt_valid  = 1'b1;
                nxt_tag    = u_tag;
                nxt_target = upd_target;
                nxt_ctr    = CTR_WEAK;
            end
        end
    end

    logic                rd_valid;
    logic [TAG_BITS-1:0] rd_tag;
    logic [XLEN-1:0]     rd_target;
    logic [CTR_BITS-1:0] rd_ctr;

    always_comb begin
        rd_valid  = valid_q[f_idx];
        rd_tag    = tag_q[f_idx];
        rd_target = target_q[f_idx];
        rd_ctr    = ctr_q[f_idx];
`ifdef BP_BYPASS_EN
        // While reset is held the write is discarded, so nothing is forwarded either.
        if (reset && upd_write && (u_idx == f_idx)) begin
            rd_valid  = nxt_valid;
            rd_tag    = nxt_tag;
            rd_target = nxt_target;
            rd_ctr    = nxt_ctr;
        end
`endif
    end

    assign pred_hit    = rd_valid && (rd_tag == f_tag);
    assign pred_taken  = pred_hit && rd_ctr[CTR_BITS-1];
    assign pred_target = pred_taken ? rd_target : fetch_pc + XLEN'(4);

    assign mispredict  = upd_valid &&
                         ((upd_taken != upd_pred_taken) ||
                          (upd_taken && (upd_target != upd_pred_target)));
    assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the table is small and its valid/ctr state must be known after reset, so every entry is cleared.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            if (upd_write) begin
                valid_q[u_idx]  <= nxt_valid;
                tag_q[u_idx]    <= nxt_tag;
                target_q[u_idx] <= nxt_target;
                ctr_q[u_idx]    <= nxt_ctr;
            end
            if (upd_valid && (branch_count != '1))
                branch_count <= branch_count + 32'd1;
            if (mispredict && (mispredict_count != '1))
                mispredict_count <= mispredict_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboard bench for branch_predictor_bht: a behavioural table model predicts every output,
// expectations are queued at drive time and compared on the following falling edge.
module tb_branch_predictor_bht;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] fetch_pc = '0;
    logic        pred_hit, pred_taken;
    logic [63:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [63:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [63:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic [63:0] upd_pred_target = '0;
    logic        mispredict;
    logic [63:0] redirect_pc;
    logic [31:0] branch_count, mispredict_count;

    branch_predictor_bht #(.XLEN(64), .ENTRIES(16), .TAG_BITS(8), .CTR_BITS(2)) dut (
        .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [63:0] target;
        logic        misp;
        logic [63:0] redir;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model of the table.
    logic        m_valid  [16];
    logic [7:0]  m_tag    [16];
    logic [63:0] m_target [16];
    logic [1:0]  m_ctr    [16];
    logic [31:0] m_bcnt, m_mcnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("pred_hit",         64'(pred_hit),         64'(e.hit));
            check("pred_taken",       64'(pred_taken),       64'(e.taken));
            check("pred_target",      pred_target,           e.target);
            check("mispredict",       64'(mispredict),       64'(e.misp));
            check("redirect_pc",      redirect_pc,           e.redir);
            check("branch_count",     64'(branch_count),     64'(e.bcnt));
            check("mispredict_count", 64'(mispredict_count), 64'(e.mcnt));
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_target[i] = '0; m_ctr[i] = '0;
        end
        m_bcnt = '0;
        m_mcnt = '0;
    endtask

    // Drive one cycle of stimulus, queue the model's expectations, then advance the model past the edge.
    task automatic step(input logic [63:0] fpc, input logic uv, input logic [63:0] upc,
                        input logic ut, input logic [63:0] utgt,
                        input logic upt, input logic [63:0] uptgt);
        logic [3:0]  fi, ui;
        logic [7:0]  ft, utg;
        logic        nv, wr, hit, taken;
        logic [7:0]  ntag;
        logic [63:0] ntgt;
        logic [1:0]  nctr;
        logic        lv;
        logic [7:0]  ltag;
        logic [63:0] ltgt;
        logic [1:0]  lctr;
        exp_t        e;
        @(posedge clk);
        #1;
        fetch_pc = fpc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
        upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt;

        fi = fpc[5:2]; ft = fpc[13:6];
        ui = upc[5:2]; utg = upc[13:6];
        nv = m_valid[ui]; ntag = m_tag[ui]; ntgt = m_target[ui]; nctr = m_ctr[ui];
        wr = 1'b0;
        if (uv && reset) begin
            if (m_valid[ui] && m_tag[ui] == utg) begin
                wr = 1'b1;
                if (ut) begin
                    ntgt = utgt;
                    nctr = (m_ctr[ui] == 2'd3) ? 2'd3 : m_ctr[ui] + 2'd1;
                end else begin
                    nctr = (m_ctr[ui] == 2'd0) ? 2'd0 : m_ctr[ui] - 2'd1;
                end
            end else if (ut) begin
                wr = 1'b1; nv = 1'b1; ntag = utg; ntgt = utgt; nctr = 2'b10;
            end
        end

        lv = m_valid[fi]; ltag = m_tag[fi]; ltgt = m_target[fi]; lctr = m_ctr[fi];
`ifdef BP_BYPASS_EN
        if (wr && ui == fi) begin
            lv = nv; ltag = ntag; ltgt = ntgt; lctr = nctr;
        end
`endif
        hit   = lv && (ltag == ft);
        taken = hit && lctr[1];
        e.hit    = hit;
        e.taken  = taken;
        e.target = taken ? ltgt : fpc + 64'd4;
        e.misp   = uv && ((ut != upt) || (ut && utgt != uptgt));
        e.redir  = ut ? utgt : upc + 64'd4;
        e.bcnt   = m_bcnt;
        e.mcnt   = m_mcnt;
        exp_q.push_back(e);

        if (reset) begin
            if (wr) begin
                m_valid[ui] = nv; m_tag[ui] = ntag; m_target[ui] = ntgt; m_ctr[ui] = nctr;
            end
            if (uv && m_bcnt != '1) m_bcnt = m_bcnt + 32'd1;
            if (e.misp && m_mcnt != '1) m_mcnt = m_mcnt + 32'd1;
        end
    endtask

    task automatic lookup(input logic [63:0] fpc);
        step(fpc, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    endtask

    task automatic train(input logic [63:0] pc, input logic taken, input logic [63:0] tgt,
                         input logic ptaken, input logic [63:0] ptgt);
        step(pc, 1'b1, pc, taken, tgt, ptaken, ptgt);
    endtask

    // Reset asserted asynchronously mid-cycle; the held-reset cycle still carries an update that must be discarded.
    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_clear();
        step(64'h100, 1'b1, 64'h100, 1'b1, 64'h40, 1'b0, 64'h104);
        @(posedge clk);
        #1;
        reset = 1'b1;
        upd_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] pcs [6];
        pcs[0] = 64'h100; pcs[1] = 64'h140; pcs[2] = 64'h200;
        pcs[3] = 64'h104; pcs[4] = 64'h3C;  pcs[5] = 64'h1000;
        model_clear();
        do_reset();

        lookup(64'h100);                                        // reset state
        train(64'h100, 1'b1, 64'h40, 1'b0, 64'h104);            // cold taken: mispredict, redirect 0x40
        lookup(64'h100);                                        // hit, taken, 0x40
        repeat (3) train(64'h100, 1'b1, 64'h40, 1'b1, 64'h40);  // saturate at 3
        repeat (3) train(64'h100, 1'b0, 64'h40, 1'b1, 64'h40);  // 2, 1, 0
        lookup(64'h100);
        train(64'h100, 1'b0, 64'h40, 1'b0, 64'h104);            // correct not-taken: no mispredict
        train(64'h100, 1'b1, 64'h40, 1'b0, 64'h104);
        train(64'h140, 1'b1, 64'h80, 1'b0, 64'h144);            // alias evicts 0x100
        lookup(64'h100);
        lookup(64'h140);

        do_reset();                                             // target change
        train(64'h100, 1'b1, 64'h40, 1'b0, 64'h104);
        train(64'h100, 1'b1, 64'h40, 1'b1, 64'h40);
        train(64'h100, 1'b1, 64'h80, 1'b1, 64'h40);
        lookup(64'h100);

        do_reset();                                             // same-cycle update and lookup
        step(64'h200, 1'b1, 64'h200, 1'b1, 64'h10, 1'b0, 64'h204);
        lookup(64'h200);
        step(64'h200, 1'b1, 64'h200, 1'b0, 64'h10, 1'b1, 64'h10);
        lookup(64'h204);

        for (int i = 0; i < 300; i++) begin
            logic [63:0] fp, up, tg;
            fp = pcs[$urandom_range(0, 5)];
            up = pcs[$urandom_range(0, 5)];
            tg = {56'h0, 2'b00, 6'($urandom_range(0, 3)) << 4};
            step(fp, 1'($urandom_range(0, 1)), up, 1'($urandom_range(0, 1)), tg,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? tg : up + 64'd4);
        end

        do_reset();                                             // reset mid-operation
        lookup(64'h100);

        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/branch_predictor_bht.md
# branch_predictor_bht

Parametrised branch target buffer with per-entry saturating direction counters. It replaces the fixed resolve-then-flush behaviour of the 5-stage core. The IF stage looks up `fetch_pc` combinationally to get a predicted next PC. The EX/MEM stage reports each resolved branch back to the block, which flags mispredictions, supplies the redirect PC for `pipeline_flush`, and trains the table.

## Interface
Parameters:
- `XLEN`, 64, PC/target width.
- `ENTRIES`, 16, table depth; power of two, ≥2. `IDX = log2(ENTRIES)`.
- `TAG_BITS`, 8, tag width; tag = `pc[IDX+2 +: TAG_BITS]`. Requires `IDX+2+TAG_BITS ≤ XLEN`.
- `CTR_BITS`, 2, direction counter width, ≥1.

Ports:
- `clk`  in  1  clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `fetch_pc`  in  XLEN  IF-stage PC to predict.
- `pred_hit`  out  1  valid entry with matching tag at `fetch_pc[IDX+1:2]`.
- `pred_taken`  out  1  `pred_hit` and counter MSB set.
- `pred_target`  out  XLEN  stored target if `pred_taken`, else `fetch_pc+4`.
- `upd_valid`  in  1  a branch resolves this cycle.
- `upd_pc`  in  XLEN  PC of resolved branch.
- `upd_taken`  in  1  actual direction.
- `upd_target`  in  XLEN  actual taken target.
- `upd_pred_taken`  in  1  prediction carried down the pipe for this branch.
- `upd_pred_target`  in  XLEN  predicted next PC carried down the pipe.
- `mispredict`  out  1  flush request.
- `redirect_pc`  out  XLEN  correct next PC.
- `branch_count`  out  32  resolved branches since reset.
- `mispredict_count`  out  32  mispredictions since reset.

## Operation
- Each entry holds `valid`, `tag[TAG_BITS]`, `target[XLEN]` and `ctr[CTR_BITS]`.
- **Lookup:** purely combinational from table registers. Index is `fetch_pc[IDX+1:2]`. `pc[1:0]` is ignored.
- **Mispredict:** combinational. It is asserted when `upd_valid` and either:
  - `upd_taken != upd_pred_taken`, or
  - `upd_taken && upd_target != upd_pred_target`.
  - `mispredict` is 0 whenever `upd_valid` is 0.
- **Redirect:** `redirect_pc = upd_taken ? upd_target : upd_pc+4`. All PC arithmetic is modulo 2^XLEN.
- **Training**, on the clock edge with `upd_valid`, at index `upd_pc[IDX+1:2]`:
  - **Tag hit:**
    - `ctr` increments if taken and decrements if not taken, saturating at `2^CTR_BITS-1` and 0.
    - If taken, `target ← upd_target`.
  - **Miss and taken:** allocate the entry, overwriting any occupant. Set `valid=1`, tag, `target=upd_target`, and `ctr` to weakly taken, i.e. `1<<(CTR_BITS-1)`.
  - **Miss and not taken:** table unchanged.
- **Statistics:**
  - `branch_count` increments on each `upd_valid`.
  - `mispredict_count` increments on each `mispredict`.
  - Both saturate at 0xFFFF_FFFF and never wrap.

## Timing
- **Reset:** all `valid=0`, all `ctr=0`, all targets 0, both counts 0. With `reset` low, outputs are `pred_hit=0`, `pred_taken=0`, `pred_target=fetch_pc+4`. `mispredict` and `redirect_pc` remain combinational from their inputs.
- **Lookup latency:** 0 cycles. `mispredict`/`redirect_pc` latency: 0 cycles (same cycle as `upd_valid`).
- **Training visibility:** 1 cycle. A lookup in the cycle after the update edge sees the new entry.
- **Same-cycle lookup and update to the same index:** lookup returns pre-update contents, unless `BP_BYPASS_EN` is defined (see below).
- **Reset mid-operation:** asserting `reset` clears table and stats immediately (asynchronous). No partial update is retained.
- **Aliasing:** two PCs with equal index and different tag evict each other. Equal index and equal tag share an entry; this is accepted.

## Configuration
- **`BP_BYPASS_EN` defined:**
  - Applies when `upd_valid` and the update index equals the lookup index in the same cycle.
  - Lookup outputs reflect the post-update entry, computed combinationally, as if written already.
  - Adds one XLEN comparator-and-mux path.
- **`BP_BYPASS_EN` undefined:** lookup always reads the registered table; no bypass logic is present.

## Test plan
- **Reset then lookup:** `reset` low then high, `fetch_pc=0x100` → `pred_hit=0`, `pred_taken=0`, `pred_target=0x104`, counts 0.
- **Cold taken branch:** `upd_pc=0x100`, `upd_taken=1`, `upd_target=0x40`, `upd_pred_taken=0`.
  - Same cycle: `mispredict=1`, `redirect_pc=0x40`.
  - Next cycle, `fetch_pc=0x100`: `pred_hit=1`, `pred_taken=1`, `pred_target=0x40`, `ctr=2'b10`.
- **Saturation:** four taken updates at 0x100, then three not-taken updates → `ctr` goes 3, 3, 3, 2, 1, 0; `pred_taken=0` from `ctr=1` onward. The next not-taken update with `upd_pred_taken=0` gives `mispredict=0` and `redirect_pc=0x104`.
- **Alias eviction:** train 0x100 taken, then train 0x140 taken (same index, different tag) → lookup 0x100 gives `pred_hit=0`, `pred_target=0x104`.
- **Target change:** entry 0x100→0x40 with `ctr=3`; update taken to 0x80 with `upd_pred_target=0x40` → `mispredict=1`, `redirect_pc=0x80`; next lookup gives target 0x80.
- **Same-cycle update and lookup** on a cold 0x200 entry, update taken to 0x10 → without `BP_BYPASS_EN`: `pred_hit=0`; with it: `pred_hit=1`, `pred_target=0x10`. In both builds, `branch_count` and `mispredict_count` increment by 1.
